// File: rtl/dmem_wait_bank.sv
// ---------------------------------------------------------------------------
// dmem_wait_bank
// Byte-addressable, big-endian data memory with per-byte write enables, a
// valid/ready request/response handshake and a fixed number of wait states
// between request accept and response.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accepted only in IDLE)
//   req_we                1 = write, 0 = read
//   req_addr              byte address of the most significant lane
//   req_wdata             write data, big-endian
//   req_be                byte enables, req_be[NB-1] = byte at req_addr
//   rsp_valid/rsp_ready   response handshake, response held until consumed
//   rsp_rdata             read data (0 for writes and faulted accesses)
//   rsp_err               access faulted, memory left untouched
//   busy                  high while an access is in flight (WAIT or RESP)
//
// Configuration
//   DMEM_MISALIGN_TRAP_EN  when defined, addresses not a multiple of NB fault.
//                          When undefined, unaligned accesses are legal.
// ---------------------------------------------------------------------------
module dmem_wait_bank #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [(DATA_W/8)-1:0]    req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Backing byte array; deliberately not reset.
    logic [7:0]          mem_q [DEPTH_BYTES];

    logic [IDX_W-1:0]    lane_idx_c [NB];
    logic [DATA_W-1:0]   rd_word_c;
    logic [SUM_W-1:0]    end_addr_c;
    logic                range_err_c;
    logic                misalign_c;
    logic                access_err_c;
    logic                commit_c;
    logic                mem_we_c;

    // Range check one bit wider than the address so addr+NB cannot wrap.
    assign end_addr_c  = {1'b0, addr_q} + SUM_W'(NB);
    assign range_err_c = end_addr_c > SUM_W'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_c = (addr_q % ADDR_W'(NB)) != '0;
`else
    assign misalign_c = 1'b0;
`endif

    assign access_err_c = range_err_c || misalign_c;

    // The access commits on the edge that leaves the last wait state.
    assign commit_c = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we_c = commit_c && we_q && !access_err_c;

    // Lane byte addresses and big-endian read assembly.
    always_comb begin
        rd_word_c = '0;
        for (int k = 0; k < int'(NB); k++) begin
            lane_idx_c[k] = IDX_W'(addr_q + ADDR_W'(k));
            rd_word_c[DATA_W-1-8*k -: 8] = mem_q[lane_idx_c[k]];
        end
    end

    // Byte-lane writes; lane k (byte at addr+k) is enabled by be[NB-1-k].
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (be_q[NB-1-k]) begin
                    mem_q[lane_idx_c[k]] <= wdata_q[DATA_W-1-8*k -: 8];
                end
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    // WAIT runs WAIT_CYCLES+1 cycles so the response lands
                    // WAIT_CYCLES+1 edges after accept.
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_err_d   = access_err_c;
                    rsp_rdata_d = (we_q || access_err_c) ? '0 : rd_word_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_wait_bank.sv
// ---------------------------------------------------------------------------
// tb_dmem_wait_bank
// Self-checking bench for dmem_wait_bank (DATA_W=32, DEPTH_BYTES=1024,
// WAIT_CYCLES=2). A byte-array reference model predicts read data, faults
// and response latency; directed cases are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_dmem_wait_bank;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WAITC  = 2;
    localparam int unsigned NB     = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int n_checks;
    int n_fail;

    logic [7:0] model_mem [DEPTH];

    dmem_wait_bank #(
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAITC),
        .INIT_FILE   ("")
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr);
        logic bad;
        bad = ({32'd0, addr} + 64'(NB)) > 64'(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % 32'(NB)) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int a;
        a = int'(addr);
        return {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int a;
        a = int'(addr);
        for (int k = 0; k < 4; k++) begin
            if (be[3-k]) model_mem[a+k] = wd[31-8*k -: 8];
        end
    endtask

    // One complete access: issue, wait for response, optionally stall it.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        exp_err = model_err(addr);
        exp_rd  = (we || exp_err) ? 32'd0 : model_read(addr);

        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // Junk on the request bus outside IDLE must be ignored.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_ready", 32'(req_ready), 32'd0);

        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(WAITC + 1));
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            check("resp_ready", 32'(req_ready), 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_rdata", rsp_rdata, exp_rd);
                check("hold_err", 32'(rsp_err), 32'(exp_err));
                check("hold_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check("done_valid", 32'(rsp_valid), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
        end
        rsp_ready = 1'b0;
        if (we && !exp_err) model_write(addr, wd, be);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole array so every later read is predictable.
        for (int i = 0; i < int'(DEPTH); i += 4) begin
            access(1'b1, 32'(i), $urandom, 4'hF, 0);
        end

        // Full-word write/read, then partial byte enables.
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        access(1'b0, 32'h10, 32'h0, 4'h0, 0);
        access(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
        access(1'b0, 32'h10, 32'h0, 4'hF, 0);

        // Range boundary, including an address whose sum would wrap 32 bits.
        access(1'b0, 32'd1021, 32'h0, 4'hF, 0);
        access(1'b0, 32'd1020, 32'h0, 4'hF, 0);
        access(1'b0, 32'hFFFF_FFFE, 32'h0, 4'hF, 0);
        access(1'b1, 32'd1022, 32'hCAFEF00D, 4'hF, 0);
        access(1'b0, 32'd1020, 32'h0, 4'hF, 0);

        // Unaligned read (faults only with the trap enabled).
        access(1'b0, 32'h11, 32'h0, 4'hF, 0);

        // be=0 write leaves memory unchanged.
        access(1'b1, 32'h20, 32'hA5A5A5A5, 4'h0, 0);
        access(1'b0, 32'h20, 32'h0, 4'hF, 0);

        // Response stalled for 5 cycles.
        access(1'b0, 32'h10, 32'h0, 4'hF, 5);

        // Reset while a write is still waiting: the write must be dropped.
        a   = 32'h40;
        old = model_read(a);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = ~old;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy0", 32'(busy), 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, a, 32'h0, 4'hF, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(1012, 1030));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 1020));
            endcase
            access(1'($urandom), a, $urandom, 4'($urandom),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
